// File: rtl/bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM state encoding and the double-dabble correction constants.
package bcd_converter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] AddThreshold = 4'd5;
  localparam logic [3:0] AddValue     = 4'd3;
  localparam logic [3:0] MaxDigit     = 4'd9;

endpackage

// File: rtl/bcd_converter_if.sv
// Operand/result handshake bundle for bcd_converter.
// master = producer/consumer side, slave = the converter.
interface bcd_converter_if #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      binary_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_en;
  logic                  busy;

  modport master (
    output in_valid, binary_in, out_ready,
    input  in_ready, out_valid, bcd, overflow, digit_en, busy
  );

  modport slave (
    input  in_valid, binary_in, out_ready,
    output in_ready, out_valid, bcd, overflow, digit_en, busy
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble per-digit correction: add 3 to any digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_converter_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= AddThreshold) ? digit_i + AddValue : digit_i;

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// with sticky overflow, optional saturation and leading-zero mask.
module bcd_converter
  import bcd_converter_pkg::*;
#(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 6,
  parameter bit          SAT_EN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bcd_converter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  if (BIN_W == 0 || BIN_W > 64) begin : g_bad_bin_w
    $error("bcd_converter: BIN_W must be in 1..64");
  end
  if (DIGITS == 0 || DIGITS > 20) begin : g_bad_digits
    $error("bcd_converter: DIGITS must be in 1..20");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]    operand_q, operand_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                overflow_q, overflow_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] step_digits;
  logic                step_ovf;
  logic [4*DIGITS-1:0] final_bcd;
  logic [DIGITS-1:0]   final_en;
  logic                any_nz;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (digits_q[4*i +: 4]),
      .digit_o (adj[4*i +: 4])
    );
  end

  // The top digit's MSB falls off the shift and feeds the sticky overflow.
  assign step_digits = {adj[4*DIGITS-2:0], operand_q[BIN_W-1]};
  assign step_ovf    = ovf_q | adj[4*DIGITS-1];
  assign final_bcd   = (step_ovf && SAT_EN) ? {DIGITS{MaxDigit}} : step_digits;

  always_comb begin
    any_nz   = 1'b0;
    final_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz      = any_nz | (|final_bcd[4*i +: 4]);
      final_en[i] = any_nz;
    end
    final_en[0] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    digit_en_d = digit_en_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d   = StShift;
          operand_d = bus.binary_in;
          digits_d  = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
        end
      end
      StShift: begin
        digits_d  = step_digits;
        operand_d = operand_q << 1;
        ovf_d     = step_ovf;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d    = StDone;
          bcd_d      = final_bcd;
          overflow_d = step_ovf;
          digit_en_d = final_en;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      operand_q  <= '0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      digit_en_q <= DIGITS'(1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      operand_q  <= operand_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.digit_en  = digit_en_q;

endmodule
